// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared CPU constants and types for the instruction-fetch stage.
//   Contents:
//     NOP_INST, ECALL_INST   - RV32I encodings the fetch stage cares about
//     DEFAULT_RESET_PC       - PC loaded on reset unless overridden
//     PC_STEP                - byte distance between sequential fetches
//     COUNT_MAX              - saturation value of the fetch counter
//     fetch_state_e          - run/halt state of the fetch stage
//     if_id_t, IF_ID_BUBBLE  - IF/ID pipeline register layout and its empty value
//     align_word()           - clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] ECALL_INST       = 32'h0000_0073;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] COUNT_MAX        = 32'hFFFF_FFFF;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  // An empty IF/ID slot carries a NOP and a zero PC so downstream stages
  // see a harmless instruction even if they ignore valid.
  localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, pc: 32'h0000_0000, inst: NOP_INST};

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
//   Program counter register with next-PC selection for the fetch stage.
//   Priority on each rising edge: reset > redirect > hold > sequential (+4).
//   Redirect targets are forced to word alignment; the +4 step wraps
//   naturally at 2^32.
//   Ports:
//     clk            in   clock
//     reset          in   synchronous active-high reset, loads RESET_PC
//     hold           in   keep the current PC (stall or halted)
//     redirect_valid in   load redirect_pc (overrides hold)
//     redirect_pc    in   redirect target byte address
//     pc             out  current PC
// ---------------------------------------------------------------------------
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  always_comb begin
    pc_next = pc + PC_STEP;
    if (redirect_valid) begin
      pc_next = align_word(redirect_pc);
    end else if (hold) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Single-issue instruction fetch stage. Presents the PC to instruction
//   memory combinationally, captures the returned word into the IF/ID
//   register one cycle later, and optionally halts after fetching ECALL.
//
//   Control semantics (no valid/ready handshake here):
//     - stall is a hold request: PC, IF/ID, halt state and counter freeze.
//     - redirect_valid overrides stall: PC jumps, IF/ID becomes a bubble,
//       halt is cleared.
//     - while halted, PC holds and IF/ID is filled with bubbles.
//
//   Ports:
//     clk            in   clock
//     reset          in   synchronous active-high reset
//     imem_addr      out  instruction memory byte address (= PC)
//     imem_dout      in   instruction word at imem_addr, same cycle
//     stall          in   hold PC and IF/ID
//     redirect_valid in   taken branch/jump this cycle
//     redirect_pc    in   branch/jump target
//     if_id_valid    out  IF/ID holds a real instruction
//     if_id_pc       out  PC of the IF/ID instruction
//     if_id_inst     out  IF/ID instruction (NOP when empty)
//     halted         out  fetch stopped after ECALL
//     fetch_count    out  saturating count of captured instructions
//     fetch_state    out  debug view of the run/halt state machine
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
  parameter bit          HALT_ON_ECALL = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  output logic [31:0]  imem_addr,
  input  logic [31:0]  imem_dout,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         if_id_valid,
  output logic [31:0]  if_id_pc,
  output logic [31:0]  if_id_inst,
  output logic         halted,
  output logic [31:0]  fetch_count,
  output fetch_state_e fetch_state
);

  fetch_state_e state_q, state_d;
  if_id_t       if_id_q, if_id_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  pc;
  logic         capture;
  logic         is_ecall;

  // PC holds while stalled or halted; redirect overrides inside pc_reg.
  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .reset          (reset),
    .hold           (stall | (state_q == FETCH_HALT)),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc)
  );

  assign imem_addr = pc;
  assign is_ecall  = HALT_ON_ECALL && (imem_dout == ECALL_INST);

  // ---- run/halt FSM: state register --------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- run/halt FSM: next state ------------------------------------------
  // Halt is entered on the same edge that captures the ECALL, so the ECALL
  // itself still lands in IF/ID as a valid instruction.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = FETCH_RUN;
    end else if (!stall && (state_q == FETCH_RUN) && is_ecall) begin
      state_d = FETCH_HALT;
    end
  end

  // ---- run/halt FSM: outputs ---------------------------------------------
  always_comb begin
    halted      = (state_q == FETCH_HALT);
    capture     = !redirect_valid && !stall && (state_q == FETCH_RUN);
    fetch_state = state_q;
  end

  // ---- IF/ID register and counter ----------------------------------------
  always_comb begin
    if_id_d = if_id_q;
    if (redirect_valid) begin
      if_id_d = IF_ID_BUBBLE;
    end else if (stall) begin
      if_id_d = if_id_q;
    end else if (capture) begin
      if_id_d = '{valid: 1'b1, pc: pc, inst: imem_dout};
    end else begin
      if_id_d = IF_ID_BUBBLE;
    end
  end

  always_comb begin
    count_d = count_q;
    if (capture && (count_q != COUNT_MAX)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_q <= IF_ID_BUBBLE;
      count_q <= 32'h0000_0000;
    end else begin
      if_id_q <= if_id_d;
      count_q <= count_d;
    end
  end

  assign if_id_valid = if_id_q.valid;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_inst  = if_id_q.inst;
  assign fetch_count = count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter HALT_ON_ECALL, default 1: enables halt on fetch of ECALL (32'h0000_0073).
REQ-003 Reset is reset: synchronous, active-high. Clock is clk.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 imem_addr  output  32  byte address to instruction memory; equals current PC.
REQ-007 imem_dout  input  32  instruction word, combinational (same-cycle) read of imem_addr.
REQ-008 stall  input  1  hazard-unit hold request for PC and IF/ID.
REQ-009 redirect_valid  input  1  branch/jump taken this cycle.
REQ-010 redirect_pc  input  32  target byte address when redirect_valid=1.
REQ-011 if_id_valid  output  1  IF/ID register holds a real instruction.
REQ-012 if_id_pc  output  32  PC of the instruction in IF/ID.
REQ-013 if_id_inst  output  32  instruction in IF/ID; NOP (32'h0000_0013) when invalid.
REQ-014 halted  output  1  fetch stopped after ECALL.
REQ-015 fetch_count  output  32  number of valid instructions captured into IF/ID.

Function
REQ-016 imem_addr SHALL be driven combinationally from the PC register, with no added latency.
REQ-017 Normal cycle (no reset, no redirect, no stall, not halted): IF/ID <= {valid=1, pc, imem_dout}; PC <= PC+4; fetch_count +1.
REQ-018 Fetch latency SHALL be one cycle: the word at PC appears on if_id_inst on the edge after PC is presented.
REQ-019 Priority per edge SHALL be: reset > redirect > stall > halted > normal.
REQ-020 Redirect: PC <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble (valid=0, inst=NOP, pc=0); halted <= 0; fetch_count unchanged; stall ignored in this cycle.
REQ-021 Stall (no redirect): PC, IF/ID, halted and fetch_count SHALL all hold.
REQ-022 Halted (no redirect, no stall): PC holds; IF/ID <= bubble; fetch_count holds.
REQ-023 With HALT_ON_ECALL=1, capture of imem_dout==32'h0000_0073 into IF/ID SHALL set halted on the same edge; the ECALL itself stays valid in IF/ID.
REQ-024 With HALT_ON_ECALL=0, ECALL SHALL be treated as an ordinary instruction.
REQ-025 PC+4 SHALL wrap modulo 2^32; fetch_count SHALL saturate at 32'hFFFF_FFFF.
REQ-026 Valid IF/ID contents SHALL never change while stall=1 and redirect_valid=0.

Reset
REQ-027 On reset: PC=RESET_PC, if_id_valid=0, if_id_inst=NOP, if_id_pc=0, halted=0, fetch_count=0.
REQ-028 Reset asserted mid-stall, mid-halt or with redirect_valid=1 SHALL override all of them.
REQ-029 On the first cycle after reset, imem_addr SHALL equal RESET_PC.

Structure
REQ-030 NOP, ECALL encoding and the default RESET_PC SHALL live in the shared CPU constants package.
REQ-031 PC register with stall/redirect next-PC selection SHALL be a sub-module pc_reg; IF/ID register, halt logic and counter stay in fetch_unit.

Verification
REQ-032 Reset, then 4 cycles with mem[0..3]=A,B,C,D -> if_id_inst A,B,C,D; if_id_pc 0,4,8,C; fetch_count 4.
REQ-033 stall=1 for 2 cycles after B is captured -> if_id_inst stays B; imem_addr stays 8; then C follows.
REQ-034 redirect_valid=1 with redirect_pc=32'h0000_0042 and stall=1 -> imem_addr 32'h40 next cycle; if_id_valid=0; count unchanged.
REQ-035 ECALL at address 8 -> halted=1 with ECALL valid in IF/ID; following cycles bubbles; imem_addr holds at C; then redirect to 0 -> halted=0, fetch resumes at 0.
REQ-036 reset asserted while halted and stall=1 -> all outputs at reset values next edge; imem_addr=RESET_PC.
REQ-037 PC=32'hFFFF_FFFC, normal cycle -> PC wraps to 32'h0000_0000.
